// File: rtl/i2c_pkg.sv
// Shared constants for the I2C processor-side register block: register offsets,
// CR/SR bit positions and register reset values.
package i2c_pkg;
   localparam int NUM_REGS = 6;

   localparam int REG_PRER = 0;
   localparam int REG_ADR  = 1;
   localparam int REG_CR   = 2;
   localparam int REG_SR   = 3;
   localparam int REG_DR   = 4;
   localparam int REG_TOR  = 5;

   localparam int CR_EN   = 7;
   localparam int CR_IEN  = 6;
   localparam int CR_MODE = 5;
   localparam int CR_MRW  = 4;
   localparam int CR_ACK  = 3;
   localparam int CR_RSTA = 2;

   localparam int SR_TIP  = 7;
   localparam int SR_AAS  = 6;
   localparam int SR_BUSY = 5;
   localparam int SR_AL   = 4;
   localparam int SR_SRW  = 3;
   localparam int SR_TO   = 2;
   localparam int SR_IF   = 1;
   localparam int SR_RXAK = 0;

   localparam logic [7:0] PRER_RST = 8'h00;
   localparam logic [7:0] ADR_RST  = 8'h00;
   localparam logic [7:0] CR_RST   = 8'h00;
   localparam logic [7:0] DR_RST   = 8'h00;
   localparam logic [7:0] TOR_RST  = 8'hFF;
endpackage

// File: rtl/i2c_proc_if_if.sv
// Processor bus cycle signals: address, write data, strobes, direction and read data.
interface i2c_proc_if_if;
   logic [7:0] add_bus;
   logic [7:0] data_in;
   logic       as;
   logic       ds;
   logic       rw;
   logic [7:0] data_out;

   modport master (output add_bus, data_in, as, ds, rw, input data_out);
   modport slave  (input add_bus, data_in, as, ds, rw, output data_out);
endinterface

// File: rtl/i2c_addr_decode.sv
// First-cycle strobe detection plus one-hot per-register write enables and read selects.
module i2c_addr_decode
   import i2c_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          add_bus,
   input  logic                as,
   input  logic                ds,
   input  logic                rw,
   output logic [NUM_REGS-1:0] we,
   output logic [NUM_REGS-1:0] rd
);
   logic       acc, acc_d, first;
   logic [7:0] off;

   assign acc   = as & ds;
   assign first = acc & ~acc_d;
   // Wrapping subtract: addresses below BASE_ADDR land far outside 0..5.
   assign off   = add_bus - BASE_ADDR;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc_d <= 1'b0;
      else      acc_d <= acc;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_sel
      assign we[r] = first & rw  & (off == 8'(r));
      assign rd[r] = acc   & ~rw & (off == 8'(r));
   end
endmodule

// File: rtl/i2c_proc_if.sv
// Processor-side register file of the I2C controller. Optional macro I2C_TIMEOUT_EN
// enables the TOR register, SR time_out bit, halt level and time_rst pulse.
module i2c_proc_if
   import i2c_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   i2c_proc_if_if.slave     bus,
   input  logic             bus_busy,
   input  logic             byte_trans,
   input  logic             slave_addressed,
   input  logic             arb_lost,
   input  logic             slave_rw,
   input  logic             inter,
   input  logic             ack_rec,
   input  logic             time_out,
   input  logic [7:0]       i2c_data,
   output logic             core_en,
   output logic             inter_en,
   output logic             mode,
   output logic             master_rw,
   output logic             ack,
   output logic             rep_start,
   output logic [7:0]       data,
   output logic [7:0]       slave_add,
   output logic [7:0]       time_out_reg,
   output logic [7:0]       prescale,
   output logic             irq,
   output logic             inter_rst,
   output logic             data_en,
   output logic             time_rst,
   output logic             halt,
   output logic [7:0]       data_out
);
   logic [NUM_REGS-1:0] we, rd;
   logic [7:2]          cr;
   logic                to_bit;
   logic [7:0]          sr_val, cr_val, rd_data;

   i2c_addr_decode #(.BASE_ADDR(BASE_ADDR)) u_dec (
      .clk     (clk),
      .rst     (rst),
      .add_bus (bus.add_bus),
      .as      (bus.as),
      .ds      (bus.ds),
      .rw      (bus.rw),
      .we      (we),
      .rd      (rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescale  <= PRER_RST;
         slave_add <= ADR_RST;
         cr        <= CR_RST[7:2];
         data      <= DR_RST;
         data_en   <= 1'b0;
         inter_rst <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (we[REG_PRER]) prescale  <= bus.data_in;
         if (we[REG_ADR])  slave_add <= bus.data_in;
         // A CPU write to CR takes priority over the rep_start self-clear.
         if (we[REG_CR])       cr          <= bus.data_in[7:2];
         else if (byte_trans)  cr[CR_RSTA] <= 1'b0;
         if (we[REG_DR])   data      <= bus.data_in;
         data_en   <= we[REG_DR];
         inter_rst <= we[REG_SR] & bus.data_in[SR_IF];
         irq       <= inter & cr[CR_IEN];
      end
   end

`ifdef I2C_TIMEOUT_EN
   logic time_out_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         time_out_reg <= TOR_RST;
         time_out_d   <= 1'b0;
         time_rst     <= 1'b0;
         halt         <= 1'b0;
      end else begin
         if (we[REG_TOR]) time_out_reg <= bus.data_in;
         time_out_d <= time_out;
         time_rst   <= we[REG_SR] & bus.data_in[SR_TO];
         if (time_out & ~time_out_d)                halt <= 1'b1;
         else if (we[REG_SR] & bus.data_in[SR_TO])  halt <= 1'b0;
      end
   end

   assign to_bit = time_out;
`else
   logic unused_tmo;

   assign unused_tmo   = time_out;
   assign time_out_reg = 8'h00;
   assign time_rst     = 1'b0;
   assign halt         = 1'b0;
   assign to_bit       = 1'b0;
`endif

   assign core_en   = cr[CR_EN];
   assign inter_en  = cr[CR_IEN];
   assign mode      = cr[CR_MODE];
   assign master_rw = cr[CR_MRW];
   assign ack       = cr[CR_ACK];
   assign rep_start = cr[CR_RSTA];

   assign cr_val = {cr, 2'b00};
   assign sr_val = {byte_trans, slave_addressed, bus_busy, arb_lost,
                    slave_rw, to_bit, inter, ack_rec};

   // rd is one-hot (or zero for unmapped addresses / no read), so an OR-mux suffices.
   always_comb begin
      rd_data = 8'h00;
      if (rd[REG_PRER]) rd_data = rd_data | prescale;
      if (rd[REG_ADR])  rd_data = rd_data | slave_add;
      if (rd[REG_CR])   rd_data = rd_data | cr_val;
      if (rd[REG_SR])   rd_data = rd_data | sr_val;
      if (rd[REG_DR])   rd_data = rd_data | i2c_data;
      if (rd[REG_TOR])  rd_data = rd_data | time_out_reg;
   end

   assign data_out     = rd_data;
   assign bus.data_out = rd_data;
endmodule

// File: tb/tb_i2c_proc_if.sv
// Directed self-checking bench for i2c_proc_if (covers both I2C_TIMEOUT_EN builds).
module tb_i2c_proc_if;
   logic       clk = 1'b0;
   logic       rst;
   logic       bus_busy, byte_trans, slave_addressed, arb_lost, slave_rw, inter, ack_rec, time_out;
   logic [7:0] i2c_data;
   logic       core_en, inter_en, mode, master_rw, ack, rep_start;
   logic [7:0] data, slave_add, time_out_reg, prescale, data_out;
   logic       irq, inter_rst, data_en, time_rst, halt;
   int         checks = 0;
   int         errors = 0;

   i2c_proc_if_if bus ();

   i2c_proc_if #(.BASE_ADDR(8'h00)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .bus_busy(bus_busy), .byte_trans(byte_trans), .slave_addressed(slave_addressed),
      .arb_lost(arb_lost), .slave_rw(slave_rw), .inter(inter), .ack_rec(ack_rec),
      .time_out(time_out), .i2c_data(i2c_data),
      .core_en(core_en), .inter_en(inter_en), .mode(mode), .master_rw(master_rw),
      .ack(ack), .rep_start(rep_start), .data(data), .slave_add(slave_add),
      .time_out_reg(time_out_reg), .prescale(prescale), .irq(irq),
      .inter_rst(inter_rst), .data_en(data_en), .time_rst(time_rst), .halt(halt),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.add_bus = a; bus.data_in = d; bus.rw = 1'b1; bus.as = 1'b1; bus.ds = 1'b1;
      @(negedge clk);
      bus.as = 1'b0; bus.ds = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.add_bus = a; bus.rw = 1'b0; bus.as = 1'b1; bus.ds = 1'b1;
      #1 d = bus.data_out;
      @(negedge clk);
      bus.as = 1'b0; bus.ds = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp_tor;
`ifdef I2C_TIMEOUT_EN
      exp_tor = 8'hFF;
`else
      exp_tor = 8'h00;
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (prescale !== 8'h00) begin errors++; $display("FAIL reset_prescale got %h exp 00", prescale); end
      checks++; if (slave_add !== 8'h00) begin errors++; $display("FAIL reset_slave_add got %h exp 00", slave_add); end
      checks++; if ({core_en, inter_en, mode, master_rw, ack, rep_start} !== 6'b0) begin
         errors++; $display("FAIL reset_cr got %b exp 000000", {core_en, inter_en, mode, master_rw, ack, rep_start}); end
      checks++; if (time_out_reg !== exp_tor) begin errors++; $display("FAIL reset_tor got %h exp %h", time_out_reg, exp_tor); end
      checks++; if ({irq, inter_rst, data_en, time_rst, halt} !== 5'b0) begin
         errors++; $display("FAIL reset_pulses got %b exp 00000", {irq, inter_rst, data_en, time_rst, halt}); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
      rst = 1'b1;
   endtask

   task automatic test_cr_hold();
      logic [7:0] r;
      // Strobe held two cycles; data changes on the second cycle, which must be ignored.
      @(negedge clk);
      bus.add_bus = 8'h02; bus.data_in = 8'hE0; bus.rw = 1'b1; bus.as = 1'b1; bus.ds = 1'b1;
      @(negedge clk);
      bus.data_in = 8'h18;
      @(negedge clk);
      bus.as = 1'b0; bus.ds = 1'b0;
      checks++; if ({core_en, inter_en, mode, master_rw, ack} !== 5'b11100) begin
         errors++; $display("FAIL cr_hold_bits got %b exp 11100", {core_en, inter_en, mode, master_rw, ack}); end
      bus_read(8'h02, r);
      checks++; if (r !== 8'hE0) begin errors++; $display("FAIL cr_read got %h exp e0", r); end
   endtask

   task automatic test_regs();
      logic [7:0] r;
      bus_write(8'h00, 8'h3C);
      bus_write(8'h01, 8'h51);
      checks++; if (prescale !== 8'h3C) begin errors++; $display("FAIL prer_write got %h exp 3c", prescale); end
      bus_read(8'h01, r);
      checks++; if (r !== 8'h51) begin errors++; $display("FAIL adr_read got %h exp 51", r); end
      bus_write(8'h07, 8'hAA);
      checks++; if (prescale !== 8'h3C || slave_add !== 8'h51) begin
         errors++; $display("FAIL unmapped_write got %h/%h exp 3c/51", prescale, slave_add); end
      bus_read(8'h06, r);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", r); end
      bus_write(8'h05, 8'h40);
      bus_read(8'h05, r);
`ifdef I2C_TIMEOUT_EN
      checks++; if (r !== 8'h40 || time_out_reg !== 8'h40) begin
         errors++; $display("FAIL tor_rw got %h/%h exp 40/40", r, time_out_reg); end
`else
      checks++; if (r !== 8'h00 || time_out_reg !== 8'h00) begin
         errors++; $display("FAIL tor_rw got %h/%h exp 00/00", r, time_out_reg); end
`endif
   endtask

   task automatic test_dr();
      logic [7:0] r;
      bus_write(8'h04, 8'h5A);
      checks++; if (data !== 8'h5A || data_en !== 1'b1) begin
         errors++; $display("FAIL dr_write got %h en %b exp 5a en 1", data, data_en); end
      @(negedge clk);
      checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL dr_pulse_width got %b exp 0", data_en); end
      i2c_data = 8'hC3;
      bus_read(8'h04, r);
      checks++; if (r !== 8'hC3) begin errors++; $display("FAIL dr_read got %h exp c3", r); end
   endtask

   task automatic test_sr_read();
      logic [7:0] r, exp_sr;
      byte_trans = 1'b1; bus_busy = 1'b1; ack_rec = 1'b1; time_out = 1'b1; slave_rw = 1'b1;
`ifdef I2C_TIMEOUT_EN
      exp_sr = 8'hAD;
`else
      exp_sr = 8'hA9;
`endif
      bus_read(8'h03, r);
      checks++; if (r !== exp_sr) begin errors++; $display("FAIL sr_read got %h exp %h", r, exp_sr); end
      byte_trans = 1'b0; bus_busy = 1'b0; ack_rec = 1'b0; time_out = 1'b0; slave_rw = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_irq();
      inter = 1'b1;
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
      bus_write(8'h03, 8'h02);
      checks++; if (inter_rst !== 1'b1) begin errors++; $display("FAIL inter_rst_pulse got %b exp 1", inter_rst); end
      @(negedge clk);
      checks++; if (inter_rst !== 1'b0) begin errors++; $display("FAIL inter_rst_width got %b exp 0", inter_rst); end
      bus_write(8'h02, 8'hA0);
      repeat (2) @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
      inter = 1'b0;
   endtask

   task automatic test_rep_start();
      logic [7:0] r;
      bus_write(8'h02, 8'h24);
      checks++; if (rep_start !== 1'b1) begin errors++; $display("FAIL rsta_set got %b exp 1", rep_start); end
      @(negedge clk);
      byte_trans = 1'b1;
      @(negedge clk);
      byte_trans = 1'b0;
      bus_read(8'h02, r);
      checks++; if (r !== 8'h20 || rep_start !== 1'b0) begin
         errors++; $display("FAIL rsta_clear got %h/%b exp 20/0", r, rep_start); end
      // CPU write setting rep_start while byte_trans is high must win.
      byte_trans = 1'b1;
      bus_write(8'h02, 8'h24);
      checks++; if (rep_start !== 1'b1) begin errors++; $display("FAIL rsta_cpu_wins got %b exp 1", rep_start); end
      byte_trans = 1'b0;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      time_out = 1'b1;
      @(negedge clk);
`ifdef I2C_TIMEOUT_EN
      checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halt); end
      bus_write(8'h03, 8'h04);
      checks++; if (time_rst !== 1'b1 || halt !== 1'b0) begin
         errors++; $display("FAIL halt_clear got rst %b halt %b exp 1 0", time_rst, halt); end
      @(negedge clk);
      checks++; if (time_rst !== 1'b0) begin errors++; $display("FAIL time_rst_width got %b exp 0", time_rst); end
`else
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_tied got %b exp 0", halt); end
      bus_write(8'h03, 8'h04);
      checks++; if (time_rst !== 1'b0) begin errors++; $display("FAIL time_rst_tied got %b exp 0", time_rst); end
`endif
      time_out = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      bus.add_bus = 8'h00; bus.data_in = 8'h99; bus.rw = 1'b1; bus.as = 1'b1; bus.ds = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++; if (prescale !== 8'h00 || rep_start !== 1'b0) begin
         errors++; $display("FAIL async_reset got %h/%b exp 00/0", prescale, rep_start); end
      @(negedge clk);
      bus.as = 1'b0; bus.ds = 1'b0;
      rst = 1'b1;
      bus_write(8'h00, 8'h11);
      checks++; if (prescale !== 8'h11) begin errors++; $display("FAIL post_reset_write got %h exp 11", prescale); end
   endtask

   initial begin
      rst = 1'b0;
      bus.add_bus = 8'h00; bus.data_in = 8'h00; bus.as = 1'b0; bus.ds = 1'b0; bus.rw = 1'b0;
      bus_busy = 1'b0; byte_trans = 1'b0; slave_addressed = 1'b0; arb_lost = 1'b0;
      slave_rw = 1'b0; inter = 1'b0; ack_rec = 1'b0; time_out = 1'b0; i2c_data = 8'h00;
      test_reset();
      test_cr_hold();
      test_regs();
      test_dr();
      test_sr_read();
      test_irq();
      test_rep_start();
      test_timeout();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
